// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared funct3 codes, state encoding and decode helpers for mem_access_unit
package mau_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] MAU_RESP_ZERO = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LD   = 2'd1,
      RMW  = 2'd2
   } state_e;

   // Stores only have B/H/W encodings; loads additionally allow BU/HU.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) begin
         return f3[2] || (f3 == 3'b011);
      end
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory signal bundle for mem_access_unit
interface mem_access_unit_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_wren;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wren
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wren
   );
endinterface

// File: rtl/mau_lane_merge.sv
// rtl/mau_lane_merge.sv - combinational load lane extract/extend and store lane merge
module mau_lane_merge
   import mau_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
);
   logic [4:0]  bsh;
   logic [4:0]  hsh;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] mask;

   always_comb begin
      bsh    = {off_i, 3'b000};
      hsh    = {off_i[1], 4'b0000};
      byte_v = 8'(word_i >> bsh);
      half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
      mask   = 32'h0;

      case (funct3_i)
         F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   load_o = {24'h0, byte_v};
         F3_H:    load_o = {{16{half_v[15]}}, half_v};
         F3_HU:   load_o = {16'h0, half_v};
         default: load_o = word_i;
      endcase

      case (funct3_i[1:0])
         2'b00: begin
            mask    = 32'h0000_00FF << bsh;
            store_o = (word_i & ~mask) | ({24'h0, wdata_i[7:0]} << bsh);
         end
         2'b01: begin
            mask    = 32'h0000_FFFF << hsh;
            store_o = (word_i & ~mask) | ({16'h0, wdata_i[15:0]} << hsh);
         end
         default: store_o = wdata_i;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store unit over word RAM; MAU_MISALIGN_TRAP_EN traps misaligned accesses
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] RESP_ZERO = MAU_RESP_ZERO
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_unit_if.slave  bus
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;

   logic              accept;
   logic              illegal;
   logic              trap;
   logic [1:0]        off_eff;
   logic [ADDR_W-1:0] req_word;
   logic              wren;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [31:0]       mem_wdata_c;
   logic [31:0]       ld_data;
   logic [31:0]       st_word;
   logic              unused_hi;

   assign req_word  = bus.req_addr[ADDR_W+1:2];
   assign unused_hi = &{1'b0, bus.req_addr[31:ADDR_W+2]};
   assign illegal   = f3_illegal(bus.req_we, bus.req_funct3);

`ifdef MAU_MISALIGN_TRAP_EN
   assign trap    = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
   assign off_eff = bus.req_addr[1:0];
`else
   // Misaligned requests are silently rounded down to their natural boundary.
   assign trap = 1'b0;
   always_comb begin
      case (bus.req_funct3[1:0])
         2'b00:   off_eff = bus.req_addr[1:0];
         2'b01:   off_eff = {bus.req_addr[1], 1'b0};
         default: off_eff = 2'b00;
      endcase
   end
`endif

   assign bus.req_ready = !rst && (state_q == IDLE);
   assign accept        = bus.req_valid && bus.req_ready;

   mau_lane_merge u_lane_merge (
      .word_i   (bus.mem_rdata),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .wdata_i  (wdata_q),
      .load_o   (ld_data),
      .store_o  (st_word)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      off_d       = off_q;
      f3_d        = f3_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      wren        = 1'b0;
      mem_addr_c  = addr_q;
      mem_wdata_c = st_word;

      case (state_q)
         IDLE: begin
            mem_addr_c = req_word;
            if (accept) begin
               if (illegal || trap) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = RESP_ZERO;
               end else if (!bus.req_we) begin
                  addr_d  = req_word;
                  off_d   = off_eff;
                  f3_d    = bus.req_funct3;
                  state_d = LD;
               end else if (bus.req_funct3[1:0] == 2'b10) begin
                  wren        = 1'b1;
                  mem_wdata_c = bus.req_wdata;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = RESP_ZERO;
               end else begin
                  addr_d  = req_word;
                  off_d   = off_eff;
                  f3_d    = bus.req_funct3;
                  wdata_d = bus.req_wdata;
                  state_d = RMW;
               end
            end
         end
         LD: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ld_data;
            state_d     = IDLE;
         end
         RMW: begin
            wren        = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = RESP_ZERO;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         off_q       <= 2'b00;
         f3_q        <= 3'b000;
         wdata_q     <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= RESP_ZERO;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Reset kills any in-flight write combinationally, so an aborted RMW never lands.
   assign bus.mem_wren  = !rst && wren;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_wdata = mem_wdata_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule
